// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive path with optional parity.
// Synchronizes rx_i, detects the start edge, samples data, parity and stop
// bits, and reports each completed frame with a one-cycle rx_valid_o pulse.
// Build option UART_RX_MAJORITY_EN: when defined, each bit is the 2-of-3
// majority of samples taken at tick counts 6, 7 and 8 (decided at 8);
// otherwise a single sample is taken at tick count 7.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a tick with rxs low
// S_START  | validating the start bit, glitches return to S_IDLE
// S_DATA   | receiving 8 data bits, LSB first
// S_PARITY | receiving the parity bit (only when latched parity enable)
// S_STOP   | sampling the stop bit, returns to S_IDLE at the decision point
module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       baud_tick_x16_i,
  input  logic       rx_i,
  input  logic       rx_en_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DEC_CNT = 4'd8;
`else
  localparam logic [3:0] DEC_CNT = 4'd7;
`endif

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [3:0]             cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic                   par_en_q, par_odd_q, par_err_q;
  logic                   tick, dec_pt, bit_end, bit_val, stop_dec;

  // Two-flop (or deeper) synchronizer; idles high so reset looks like an idle line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic s6_q, s7_q;

  // Capture the two early samples that feed the majority vote at count 8.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s6_q <= 1'b1;
      s7_q <= 1'b1;
    end else if (tick) begin
      if (cnt_q == 4'd6) s6_q <= rxs;
      if (cnt_q == 4'd7) s7_q <= rxs;
    end
  end

  assign bit_val = (s6_q & s7_q) | (s6_q & rxs) | (s7_q & rxs);
`else
  assign bit_val = rxs;
`endif

  assign tick     = baud_tick_x16_i;
  assign dec_pt   = tick && (cnt_q == DEC_CNT);
  assign bit_end  = tick && (cnt_q == 4'd15);
  assign stop_dec = rx_en_i && (state_q == S_STOP) && dec_pt;
  assign busy_o   = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; disabling the receiver overrides everything.
  always_comb begin
    state_d = state_q;
    if (!rx_en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (tick && !rxs) state_d = S_START;
        S_START: begin
          if (dec_pt && bit_val) state_d = S_IDLE;
          else if (bit_end)      state_d = S_DATA;
        end
        S_DATA:   if (bit_end && (bit_idx_q == 3'd7)) state_d = par_en_q ? S_PARITY : S_STOP;
        S_PARITY: if (bit_end) state_d = S_STOP;
        S_STOP:   if (dec_pt) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Tick counter: held at zero while idle or disabled, so the start tick restarts it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            cnt_q <= '0;
    else if (!rx_en_i || state_q == S_IDLE) cnt_q <= '0;
    else if (tick)                          cnt_q <= cnt_q + 4'd1;
  end

  // Frame datapath: config latch at start, shift register, parity check, result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_err_q    <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (state_q == S_IDLE && state_d == S_START) begin
        par_en_q  <= parity_en_i;
        par_odd_q <= parity_odd_i;
        bit_idx_q <= '0;
      end
      if (state_q == S_DATA && dec_pt)  shift_q   <= {bit_val, shift_q[7:1]};
      if (state_q == S_DATA && bit_end) bit_idx_q <= bit_idx_q + 3'd1;
      if (state_q == S_PARITY && dec_pt)
        par_err_q <= (^shift_q ^ bit_val) != par_odd_q;
      if (stop_dec) begin
        rx_valid_o   <= 1'b1;
        rx_data_o    <= shift_q;
        frame_err_o  <= ~bit_val;
        parity_err_o <= par_en_q & par_err_q;
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on rx_i (legal 2..4).
REQ-002 clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 baud_tick_x16_i  input  1  one-clk pulse at 16x the baud rate, from the shared baud generator.
REQ-005 rx_i  input  1  asynchronous serial line; idles high.
REQ-006 rx_en_i  input  1  receiver enable.
REQ-007 parity_en_i  input  1  parity bit present after the data bits.
REQ-008 parity_odd_i  input  1  1 = odd parity, 0 = even; ignored when parity_en_i=0.
REQ-009 rx_data_o  output  8  last received byte.
REQ-010 rx_valid_o  output  1  one-clk pulse when a frame completes.
REQ-011 parity_err_o  output  1  parity mismatch on the last frame.
REQ-012 frame_err_o  output  1  stop bit sampled low on the last frame.
REQ-013 busy_o  output  1  high in every state except IDLE.

Function
REQ-014 rx_i shall pass through SYNC_STAGES flops reset to 1; all logic uses the synchronized value rxs.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 A 4-bit tick counter shall count baud ticks 0..15 within each bit period, wrapping 15->0; it advances only on baud_tick_x16_i.
REQ-017 IDLE->START on a tick with rxs=0; counter cleared to 0.
REQ-018 Bit decision point is counter=7 (single sample of rxs) unless REQ-031 applies.
REQ-019 START: at the decision point, rxs=1 -> IDLE (glitch rejected, no outputs change); rxs=0 -> remain START until counter=15, then DATA.
REQ-020 DATA: 8 bits, LSB first; each bit decided at the decision point, shifted into a shift register; after bit 7 at counter=15 -> PARITY if parity_en_i, else STOP.
REQ-021 PARITY: at the decision point, compute error = (XOR of 8 data bits XOR sampled bit) != parity_odd_i; at counter=15 -> STOP.
REQ-022 STOP: at the decision point, go directly to IDLE (no wait for counter=15) so back-to-back frames are accepted.
REQ-023 On the clk after the stop decision: rx_valid_o=1 for exactly one cycle; rx_data_o, parity_err_o and frame_err_o load simultaneously and hold until the next frame completes.
REQ-024 frame_err_o=1 if the stop sample is 0; the frame is still reported with rx_valid_o=1.
REQ-025 parity_err_o=0 for frames received with parity_en_i=0.
REQ-026 parity_en_i and parity_odd_i are sampled at IDLE->START; changes mid-frame have no effect on that frame.
REQ-027 rx_en_i=0 forces IDLE on the next clk and clears the counter; a partial frame is discarded (no rx_valid_o); data/error outputs hold.

Reset
REQ-028 With rst_ni=0: state=IDLE, counter=0, synchronizer=all 1, rx_data_o=0x00, rx_valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0.
REQ-029 Reset mid-frame aborts the frame with no rx_valid_o; reception resumes at the next start edge after release.

Configuration
REQ-030 Macro UART_RX_MAJORITY_EN selects the sampling scheme.
REQ-031 Defined: rxs is sampled at counters 6, 7 and 8; the bit value is the 2-of-3 majority, and the decision point (REQ-018..022) is counter=8.
REQ-032 Undefined: single sample at counter=7; no majority logic is present.

Verification
REQ-033 Parity off, line sends 0xA5 as 8N1 -> one rx_valid_o pulse, rx_data_o=0xA5, parity_err_o=0, frame_err_o=0, busy_o=0 afterwards.
REQ-034 Even parity, 0x03 with parity bit 0 -> parity_err_o=0; 0x03 with parity bit 1 -> parity_err_o=1; odd parity, 0x03 with parity bit 1 -> parity_err_o=0.
REQ-035 0x55 with stop bit driven 0 -> rx_valid_o pulse, rx_data_o=0x55, frame_err_o=1; a following 0x12 frame -> frame_err_o=0.
REQ-036 Idle line pulled low for 4 ticks -> no rx_valid_o, busy_o returns to 0 at counter=7/8, rx_data_o unchanged.
REQ-037 rst_ni pulsed low during data bit 3 -> all outputs at reset values, no rx_valid_o; a next frame 0x3C -> rx_data_o=0x3C.
REQ-038 Back-to-back 0xF0,0x0F with no idle gap -> two rx_valid_o pulses with correct data; with UART_RX_MAJORITY_EN, a one-tick inverted glitch at counter=7 of bit 0 leaves the data correct.
